// File: rtl/cpl_serial_adder_ctrl_if.sv
// Handshake and operand/result bus between the synchronous datapath and the CPL serial controller.
// The subtract request port exists only when CPL_SERIAL_SUB_EN is defined.
interface cpl_serial_adder_ctrl_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
`ifdef CPL_SERIAL_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         rail_err;

`ifdef CPL_SERIAL_SUB_EN
  modport master (
    output start, op_a, op_b, cin, sub,
    input  busy, done, result, cout, rail_err
  );

  modport slave (
    input  start, op_a, op_b, cin, sub,
    output busy, done, result, cout, rail_err
  );
`else
  modport master (
    output start, op_a, op_b, cin,
    input  busy, done, result, cout, rail_err
  );

  modport slave (
    input  start, op_a, op_b, cin,
    output busy, done, result, cout, rail_err
  );
`endif
endinterface

// File: rtl/cpl_serial_adder_ctrl.sv
// Bit-serial initiator for a dual-rail CPL full-adder cell: drives complementary A/B/C rails LSB first,
// samples Sum/Carry after SETTLE cycles, chains the carry and checks rail complementarity.
// Optional macro CPL_SERIAL_SUB_EN adds a subtract mode (B rails inverted, bit-0 carry forced to 1).
module cpl_serial_adder_ctrl #(
  parameter int W      = 8,
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  cpl_serial_adder_ctrl_if.slave bus,
  output logic fa_a,
  output logic fa_abar,
  output logic fa_b,
  output logic fa_bbar,
  output logic fa_c,
  output logic fa_cbar,
  input  logic fa_sum,
  input  logic fa_sumbar,
  input  logic fa_carry,
  input  logic fa_carrybar
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-2:0]  sum_sr;
  logic [W-1:0]  result_q;
  logic          cout_q;
  logic          rail_err_q;

  logic          accept;
  logic          sample;
  logic          last_cnt;
  logic          last_bit;
  logic          rail_bad;
  logic [W-1:0]  b_in;
  logic          c_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    sample    = 1'b0;
    last_cnt  = (cnt == CW'(SETTLE - 1));
    last_bit  = (idx == IW'(W - 1));
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (last_cnt) begin
          sample = 1'b1;
          if (last_bit) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Subtraction is a + ~b + 1, so B is stored already inverted and the carry chain starts at 1.
  always_comb begin
`ifdef CPL_SERIAL_SUB_EN
    b_in = bus.sub ? ~bus.op_b : bus.op_b;
    c_in = bus.sub | bus.cin;
`else
    b_in = bus.op_b;
    c_in = bus.cin;
`endif
  end

  assign rail_bad = (fa_sum == fa_sumbar) || (fa_carry == fa_carrybar);

  // Operands are kept as shift registers so the next bit to drive is always at position 0;
  // the rails themselves act as the carry register between bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      cnt        <= '0;
      a_sh       <= '0;
      b_sh       <= '0;
      sum_sr     <= '0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      rail_err_q <= 1'b0;
      fa_a       <= 1'b0;
      fa_abar    <= 1'b0;
      fa_b       <= 1'b0;
      fa_bbar    <= 1'b0;
      fa_c       <= 1'b0;
      fa_cbar    <= 1'b0;
    end else if (accept) begin
      idx        <= '0;
      cnt        <= '0;
      a_sh       <= {1'b0, bus.op_a[W-1:1]};
      b_sh       <= {1'b0, b_in[W-1:1]};
      sum_sr     <= '0;
      rail_err_q <= 1'b0;
      fa_a       <= bus.op_a[0];
      fa_abar    <= ~bus.op_a[0];
      fa_b       <= b_in[0];
      fa_bbar    <= ~b_in[0];
      fa_c       <= c_in;
      fa_cbar    <= ~c_in;
    end else if (state == DRIVE) begin
      if (sample) begin
        cnt <= '0;
        if (rail_bad) begin
          rail_err_q <= 1'b1;
        end
        if (last_bit) begin
          result_q <= {fa_sum, sum_sr};
          cout_q   <= fa_carry;
          fa_a     <= 1'b0;
          fa_abar  <= 1'b0;
          fa_b     <= 1'b0;
          fa_bbar  <= 1'b0;
          fa_c     <= 1'b0;
          fa_cbar  <= 1'b0;
        end else begin
          sum_sr[idx] <= fa_sum;
          idx         <= idx + IW'(1);
          a_sh        <= {1'b0, a_sh[W-1:1]};
          b_sh        <= {1'b0, b_sh[W-1:1]};
          fa_a        <= a_sh[0];
          fa_abar     <= ~a_sh[0];
          fa_b        <= b_sh[0];
          fa_bbar     <= ~b_sh[0];
          fa_c        <= fa_carry;
          fa_cbar     <= ~fa_carry;
        end
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign bus.busy     = (state == DRIVE);
  assign bus.done     = (state == DONE);
  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.rail_err = rail_err_q;

endmodule

// File: tb/tb_cpl_serial_adder_ctrl.sv
// Scoreboard bench for cpl_serial_adder_ctrl with a behavioural dual-rail full-adder cell
// that can force a sum-rail fault; expectations are hand-computed directed vectors.
module tb_cpl_serial_adder_ctrl;

  localparam int W      = 8;
  localparam int SETTLE = 2;
  localparam int LAT    = W * SETTLE;

  typedef struct packed {
    logic [W-1:0] result;
    logic         cout;
    logic         rail_err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fa_a, fa_abar, fa_b, fa_bbar, fa_c, fa_cbar;
  logic fa_sum, fa_sumbar, fa_carry, fa_carrybar;
  logic fault = 1'b0;
  logic sum_t, carry_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  cpl_serial_adder_ctrl_if #(.W(W)) bus ();

  cpl_serial_adder_ctrl #(.W(W), .SETTLE(SETTLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .fa_a        (fa_a),
    .fa_abar     (fa_abar),
    .fa_b        (fa_b),
    .fa_bbar     (fa_bbar),
    .fa_c        (fa_c),
    .fa_cbar     (fa_cbar),
    .fa_sum      (fa_sum),
    .fa_sumbar   (fa_sumbar),
    .fa_carry    (fa_carry),
    .fa_carrybar (fa_carrybar)
  );

  always #5 clk = ~clk;

  // The cell model only looks at the true rails; the fault drives both sum rails high.
  assign sum_t       = fa_a ^ fa_b ^ fa_c;
  assign carry_t     = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);
  assign fa_sum      = fault ? 1'b1 : sum_t;
  assign fa_sumbar   = fault ? 1'b1 : ~sum_t;
  assign fa_carry    = carry_t;
  assign fa_carrybar = ~carry_t;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.busy) begin
        checkOutput("rails_complementary",
                    {29'b0, fa_a ^ fa_abar, fa_b ^ fa_bbar, fa_c ^ fa_cbar}, 32'h7);
      end else begin
        checkOutput("rails_spacer", {26'b0, fa_a, fa_abar, fa_b, fa_bbar, fa_c, fa_cbar}, 32'h0);
      end
      if (bus.done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got done=1, expected no pending operation");
        end else begin
          mon_e = sb.pop_front();
          checkOutput("result", {24'b0, bus.result}, {24'b0, mon_e.result});
          checkOutput("cout", {31'b0, bus.cout}, {31'b0, mon_e.cout});
          checkOutput("rail_err_at_done", {31'b0, bus.rail_err}, {31'b0, mon_e.rail_err});
        end
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                               input logic s, input logic [W-1:0] exp_res, input logic exp_cout,
                               input int fault_bit, input logic hold);
    exp_t e;
    bit   got;
    e.result   = exp_res;
    e.cout     = exp_cout;
    e.rail_err = (fault_bit >= 0);
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.cin   = c;
`ifdef CPL_SERIAL_SUB_EN
    bus.sub   = s;
`else
    if (s) $display("[TB] subtract vector skipped: feature disabled");
`endif
    @(posedge clk);
    #1 bus.start = hold;
    @(negedge clk);
    checkOutput("busy_after_start", {31'b0, bus.busy}, 32'h1);
    checkOutput("rail_err_cleared", {31'b0, bus.rail_err}, 32'h0);
    got = 1'b0;
    for (int n = 1; n <= LAT + 8 && !got; n++) begin
      @(posedge clk);
      #1;
      if (fault_bit >= 0) begin
        if (n == SETTLE * fault_bit) fault = 1'b1;
        if (n == SETTLE * (fault_bit + 1)) fault = 1'b0;
      end
      if (hold) begin
        bus.op_a = bus.op_a + 8'h11;
        bus.op_b = bus.op_b ^ 8'hA5;
        bus.cin  = ~bus.cin;
      end
      @(negedge clk);
      if (bus.done) begin
        got = 1'b1;
        checkOutput("latency", n, LAT);
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got no done within %0d cycles, expected done after %0d", LAT + 8, LAT);
    end
    fault = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    checkOutput("busy_after_done", {31'b0, bus.busy}, 32'h0);
    checkOutput("done_single_pulse", {31'b0, bus.done}, 32'h0);
    checkOutput("rail_err_held", {31'b0, bus.rail_err}, {31'b0, e.rail_err});
  endtask

  task automatic resetMidOperation();
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_a  = 8'hC3;
    bus.op_b  = 8'h5F;
    bus.cin   = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy", {31'b0, bus.busy}, 32'h0);
    checkOutput("reset_done", {31'b0, bus.done}, 32'h0);
    checkOutput("reset_result", {24'b0, bus.result}, 32'h0);
    checkOutput("reset_cout", {31'b0, bus.cout}, 32'h0);
    checkOutput("reset_rails", {26'b0, fa_a, fa_abar, fa_b, fa_bbar, fa_c, fa_cbar}, 32'h0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    bus.cin   = 1'b0;
`ifdef CPL_SERIAL_SUB_EN
    bus.sub   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("init_busy", {31'b0, bus.busy}, 32'h0);
    checkOutput("init_done", {31'b0, bus.done}, 32'h0);
    checkOutput("init_result", {24'b0, bus.result}, 32'h0);
    checkOutput("init_cout", {31'b0, bus.cout}, 32'h0);
    checkOutput("init_rail_err", {31'b0, bus.rail_err}, 32'h0);

    applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, -1, 1'b0);
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, -1, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, -1, 1'b0);
    applyStimulus(8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, -1, 1'b0);
    applyStimulus(8'hA5, 8'h0F, 1'b0, 1'b0, 8'hBC, 1'b0, 3, 1'b0);
    applyStimulus(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, -1, 1'b0);
    resetMidOperation();
    applyStimulus(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, -1, 1'b0);
    applyStimulus(8'h77, 8'h11, 1'b1, 1'b0, 8'h89, 1'b0, -1, 1'b1);
`ifdef CPL_SERIAL_SUB_EN
    applyStimulus(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, -1, 1'b0);
    applyStimulus(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, -1, 1'b0);
`endif

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
